// File: rtl/bfm_ahb_cmd_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : bfm_ahb_cmd_master_if
//  Purpose  : Bundle of the command/response handshake and AHB-Lite master
//             bus signals used by bfm_ahb_cmd_master.
//  Modports : master - the command master (drives the AHB request side and the
//                      response port).
//             slave  - the environment (command source, response sink and
//                      AHB slave return path).
//  Revision : 1.0 - initial release
// ============================================================================
interface bfm_ahb_cmd_master_if #(
    parameter int AWIDTH = 10
) ();
    // Command port
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WRITE;
    logic [AWIDTH-1:0] CMD_ADDR;
    logic [2:0]        CMD_SIZE;
    logic [31:0]       CMD_WDATA;
    // Response port
    logic              RSP_VALID;
    logic [31:0]       RSP_RDATA;
    logic              RSP_ERR;
    logic              RSP_TMO;
    logic              BUSY;
    // AHB-Lite master side
    logic              HSEL;
    logic [AWIDTH-1:0] HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [1:0]        HTRANS;
    logic [2:0]        HBURST;
    logic              HMASTLOCK;
    logic [3:0]        HPROT;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
        input  HRDATA, HREADY, HRESP,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TMO, BUSY,
        output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HMASTLOCK, HPROT, HWDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_WDATA,
        output HRDATA, HREADY, HRESP,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TMO, BUSY,
        input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HMASTLOCK, HPROT, HWDATA
    );
endinterface
`default_nettype wire

// File: rtl/bfm_ahb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : bfm_ahb_cmd_master
//  Purpose  : Command-driven AHB-Lite master. Each accepted command becomes a
//             single NONSEQ transfer; address and data phases are pipelined so
//             back-to-back commands sustain one transfer per cycle. Every
//             completed transfer returns a one-cycle response pulse, in order.
//  Ports    : HCLK   - clock, rising edge
//             HRESET - synchronous active-high reset
//             bus    - bfm_ahb_cmd_master_if.master (command, response, AHB)
//  Options  : BFM_AHBMASTER_TIMEOUT_EN - when defined, a data phase stalled
//             for TIMEOUT consecutive HREADY=0 cycles is abandoned with
//             RSP_ERR=1 and RSP_TMO=1. Undefined: waits indefinitely.
//  Revision : 1.0 - initial release
// ============================================================================
module bfm_ahb_cmd_master #(
    parameter int AWIDTH  = 10,
    parameter int TIMEOUT = 256
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    bfm_ahb_cmd_master_if.master bus
);

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] c_HSIZE_MAX     = 3'd2;
    localparam logic [3:0] c_HPROT         = 4'b0011;

    // Address-phase stage
    logic              r_a_vld;
    logic [AWIDTH-1:0] r_a_addr;
    logic              r_a_write;
    logic [2:0]        r_a_size;
    logic [31:0]       r_a_wdata;
    // Data-phase stage
    logic              r_d_vld;
    logic              r_d_write;
    logic [31:0]       r_d_wdata;
    // Between the two cycles of an ERROR response
    logic              r_err_hold;
    // Response registers
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_rdata;

    logic              w_stall;
    logic              w_adv;
    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_done;
    logic              w_err_first;
    logic              w_tmo_fire;
    logic              w_tmo_hold;
    logic [2:0]        w_cmd_size;

    assign w_cmd_size  = (bus.CMD_SIZE > c_HSIZE_MAX) ? c_HSIZE_MAX : bus.CMD_SIZE;
    // While stalled the A-stage is not on the bus (IDLE), so it must not move.
    assign w_stall     = r_err_hold || w_tmo_hold;
    assign w_adv       = bus.HREADY && !w_stall;
    assign w_cmd_ready = !r_a_vld || w_adv;
    assign w_accept    = bus.CMD_VALID && w_cmd_ready;
    assign w_done      = r_d_vld && bus.HREADY;
    assign w_err_first = r_d_vld && !bus.HREADY && bus.HRESP;

`ifdef BFM_AHBMASTER_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_tmo_cnt;
    logic        r_tmo_hold;
    logic        r_rsp_tmo;

    // Fires on the TIMEOUT-th consecutive sampled wait state.
    assign w_tmo_fire = r_d_vld && !bus.HREADY && (r_tmo_cnt == c_TMO_LAST);
    assign w_tmo_hold = r_tmo_hold;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_tmo_cnt  <= 16'd0;
            r_tmo_hold <= 1'b0;
            r_rsp_tmo  <= 1'b0;
        end else begin
            if (bus.HREADY) begin
                r_tmo_cnt <= 16'd0;
            end else if (r_d_vld) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
            // After abandoning, stay off the bus until the slave is ready again.
            if (bus.HREADY) begin
                r_tmo_hold <= 1'b0;
            end else if (w_tmo_fire) begin
                r_tmo_hold <= 1'b1;
            end
            r_rsp_tmo <= w_tmo_fire;
        end
    end

    assign bus.RSP_TMO = r_rsp_tmo;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_tmo_fire       = 1'b0;
    assign w_tmo_hold       = 1'b0;
    assign bus.RSP_TMO      = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_a_vld     <= 1'b0;
            r_a_addr    <= '0;
            r_a_write   <= 1'b0;
            r_a_size    <= 3'd0;
            r_a_wdata   <= 32'd0;
            r_d_vld     <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_wdata   <= 32'd0;
            r_err_hold  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            // An empty A-stage may load even while the pipeline is stalled.
            // Address fields are kept when the stage empties so HADDR stays put.
            if (w_adv || !r_a_vld) begin
                r_a_vld <= w_accept;
                if (w_accept) begin
                    r_a_addr  <= bus.CMD_ADDR;
                    r_a_write <= bus.CMD_WRITE;
                    r_a_size  <= w_cmd_size;
                    r_a_wdata <= bus.CMD_WDATA;
                end
            end

            if (w_adv) begin
                r_d_vld   <= r_a_vld;
                r_d_write <= r_a_write;
                r_d_wdata <= r_a_wdata;
            end else if (w_done || w_tmo_fire) begin
                // Second ERROR cycle or abandon: the bus was IDLE, nothing follows.
                r_d_vld <= 1'b0;
            end

            if (w_tmo_fire) begin
                r_err_hold <= 1'b0;
            end else if (r_err_hold && bus.HREADY) begin
                r_err_hold <= 1'b0;
            end else if (w_err_first) begin
                r_err_hold <= 1'b1;
            end

            r_rsp_valid <= w_done || w_tmo_fire;
            r_rsp_err   <= (w_done && bus.HRESP) || w_tmo_fire;
            r_rsp_rdata <= (w_done && !r_d_write && !bus.HRESP) ? bus.HRDATA : 32'd0;
        end
    end

    assign bus.CMD_READY = w_cmd_ready;
    assign bus.RSP_VALID = r_rsp_valid;
    assign bus.RSP_ERR   = r_rsp_err;
    assign bus.RSP_RDATA = r_rsp_rdata;
    assign bus.BUSY      = r_a_vld || r_d_vld;

    assign bus.HTRANS    = (r_a_vld && !w_stall) ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
    assign bus.HSEL      = r_a_vld && !w_stall;
    assign bus.HADDR     = r_a_addr;
    assign bus.HWRITE    = r_a_write;
    assign bus.HSIZE     = r_a_size;
    assign bus.HWDATA    = r_d_wdata;
    assign bus.HBURST    = 3'b000;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HPROT     = c_HPROT;

endmodule
`default_nettype wire

// File: tb/tb_bfm_ahb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bfm_ahb_cmd_master
//  Purpose  : Self-checking bench for bfm_ahb_cmd_master. Directed stimulus
//             pushes expected responses into a queue; a monitor pops and
//             compares each RSP_VALID pulse. Bus timing is checked inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bfm_ahb_cmd_master;

    localparam int AW = 10;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic HCLK = 1'b0;
    logic HRESET;
    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;

    always #5 HCLK = ~HCLK;

    bfm_ahb_cmd_master_if #(.AWIDTH(AW)) bus ();

    bfm_ahb_cmd_master #(.AWIDTH(AW), .TIMEOUT(8)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push(input logic [31:0] rd, input logic er, input logic tm);
        rsp_t e;
        e.rdata = rd;
        e.err   = er;
        e.tmo   = tm;
        exp_q.push_back(e);
    endtask

    task automatic set_cmd(input logic wr, input logic [AW-1:0] a, input logic [2:0] sz,
                           input logic [31:0] wd);
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = wr;
        bus.CMD_ADDR  = a;
        bus.CMD_SIZE  = sz;
        bus.CMD_WDATA = wd;
    endtask

    // Offers a command and returns 1 ns after the accepting edge (cycle N+1).
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [2:0] sz,
                         input logic [31:0] wd);
        int budget;
        budget = 0;
        set_cmd(wr, a, sz, wd);
        @(negedge HCLK);
        while (!bus.CMD_READY && budget < 50) begin
            @(negedge HCLK);
            budget++;
        end
        if (!bus.CMD_READY) chk("cmd_accept_wait", 32'd0, 32'd1);
        tick();
        bus.CMD_VALID = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge HCLK) begin
        if (!HRESET && bus.RSP_VALID) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", bus.RSP_RDATA, mon_e.rdata);
                chk("rsp_err", {31'd0, bus.RSP_ERR}, {31'd0, mon_e.err});
                chk("rsp_tmo", {31'd0, bus.RSP_TMO}, {31'd0, mon_e.tmo});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET        = 1'b1;
        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = '0;
        bus.CMD_SIZE  = 3'd0;
        bus.CMD_WDATA = 32'd0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = 32'd0;
        repeat (3) tick();
        HRESET = 1'b0;

        // ---- reset values ----
        @(negedge HCLK);
        chk("rst_cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
        chk("rst_htrans", {30'd0, bus.HTRANS}, 32'd0);
        chk("rst_hsel", {31'd0, bus.HSEL}, 32'd0);
        chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.RSP_VALID}, 32'd0);
        chk("hprot", {28'd0, bus.HPROT}, 32'h3);
        chk("hburst", {29'd0, bus.HBURST}, 32'd0);
        chk("hmastlock", {31'd0, bus.HMASTLOCK}, 32'd0);
        tick();

        // ---- single write, zero wait ----
        push(32'd0, 1'b0, 1'b0);
        issue(1'b1, 10'h040, 3'd2, 32'hA5A5_0001);
        @(negedge HCLK);
        chk("wr_htrans_n1", {30'd0, bus.HTRANS}, 32'h2);
        chk("wr_hsel_n1", {31'd0, bus.HSEL}, 32'd1);
        chk("wr_haddr_n1", {22'd0, bus.HADDR}, 32'h040);
        chk("wr_hwrite_n1", {31'd0, bus.HWRITE}, 32'd1);
        chk("wr_hsize_n1", {29'd0, bus.HSIZE}, 32'd2);
        tick();
        @(negedge HCLK);
        chk("wr_hwdata_n2", bus.HWDATA, 32'hA5A5_0001);
        chk("wr_htrans_n2", {30'd0, bus.HTRANS}, 32'd0);
        chk("wr_rsp_n2", {31'd0, bus.RSP_VALID}, 32'd0);
        tick();
        @(negedge HCLK);
        chk("wr_rsp_n3", {31'd0, bus.RSP_VALID}, 32'd1);
        tick();

        // ---- read with two wait states ----
        push(32'h1234_5678, 1'b0, 1'b0);
        issue(1'b0, 10'h044, 3'd2, 32'd0);
        @(negedge HCLK);
        chk("rd_htrans_n1", {30'd0, bus.HTRANS}, 32'h2);
        chk("rd_hwrite_n1", {31'd0, bus.HWRITE}, 32'd0);
        tick();
        bus.HREADY = 1'b0;
        @(negedge HCLK);
        chk("rd_haddr_w1", {22'd0, bus.HADDR}, 32'h044);
        chk("rd_busy_w1", {31'd0, bus.BUSY}, 32'd1);
        tick();
        @(negedge HCLK);
        chk("rd_haddr_w2", {22'd0, bus.HADDR}, 32'h044);
        chk("rd_rsp_w2", {31'd0, bus.RSP_VALID}, 32'd0);
        tick();
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'h1234_5678;
        @(negedge HCLK);
        chk("rd_rsp_n4", {31'd0, bus.RSP_VALID}, 32'd0);
        tick();
        bus.HRDATA = 32'd0;
        @(negedge HCLK);
        chk("rd_rsp_n5", {31'd0, bus.RSP_VALID}, 32'd1);
        tick();

        // ---- four back-to-back writes, one with an oversized HSIZE ----
        begin
            logic [2:0]  sz_in  [4];
            logic [2:0]  sz_exp [4];
            logic [31:0] wd     [4];
            sz_in  = '{3'd0, 3'd7, 3'd1, 3'd2};
            sz_exp = '{3'd0, 3'd2, 3'd1, 3'd2};
            wd     = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C};
            for (int i = 0; i < 4; i++) push(32'd0, 1'b0, 1'b0);
            set_cmd(1'b1, 10'h000, sz_in[0], wd[0]);
            @(negedge HCLK);
            chk("b2b_ready_0", {31'd0, bus.CMD_READY}, 32'd1);
            for (int i = 0; i < 4; i++) begin
                tick();
                if (i < 3) set_cmd(1'b1, 10'(4 * (i + 1)), sz_in[i+1], wd[i+1]);
                else bus.CMD_VALID = 1'b0;
                @(negedge HCLK);
                chk("b2b_htrans", {30'd0, bus.HTRANS}, 32'h2);
                chk("b2b_haddr", {22'd0, bus.HADDR}, 32'(4 * i));
                chk("b2b_hsize", {29'd0, bus.HSIZE}, {29'd0, sz_exp[i]});
                if (i < 3) chk("b2b_ready", {31'd0, bus.CMD_READY}, 32'd1);
                if (i >= 1) chk("b2b_hwdata", bus.HWDATA, wd[i-1]);
                if (i >= 2) chk("b2b_rsp", {31'd0, bus.RSP_VALID}, 32'd1);
            end
            tick();
            @(negedge HCLK);
            chk("b2b_hwdata_last", bus.HWDATA, wd[3]);
            chk("b2b_htrans_idle", {30'd0, bus.HTRANS}, 32'd0);
            chk("b2b_rsp_3", {31'd0, bus.RSP_VALID}, 32'd1);
            tick();
            @(negedge HCLK);
            chk("b2b_rsp_4", {31'd0, bus.RSP_VALID}, 32'd1);
            tick();
            @(negedge HCLK);
            chk("b2b_rsp_end", {31'd0, bus.RSP_VALID}, 32'd0);
            tick();
        end

        // ---- write errors while a read is pending in the address phase ----
        push(32'd0, 1'b1, 1'b0);
        push(32'hCAFE_0014, 1'b0, 1'b0);
        set_cmd(1'b1, 10'h010, 3'd2, 32'hBEEF_0010);
        tick();                                  // write accepted
        set_cmd(1'b0, 10'h014, 3'd2, 32'd0);
        tick();                                  // read accepted; write in data phase
        bus.CMD_VALID = 1'b0;
        bus.HREADY    = 1'b0;
        bus.HRESP     = 1'b1;
        @(negedge HCLK);
        chk("err_htrans_c1", {30'd0, bus.HTRANS}, 32'h2);
        chk("err_haddr_c1", {22'd0, bus.HADDR}, 32'h014);
        tick();
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'hDEAD_DEAD;
        @(negedge HCLK);
        chk("err_htrans_c2", {30'd0, bus.HTRANS}, 32'd0);
        chk("err_ready_c2", {31'd0, bus.CMD_READY}, 32'd0);
        tick();
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'd0;
        @(negedge HCLK);
        chk("err_rsp", {31'd0, bus.RSP_VALID}, 32'd1);
        chk("err_reissue_htrans", {30'd0, bus.HTRANS}, 32'h2);
        chk("err_reissue_haddr", {22'd0, bus.HADDR}, 32'h014);
        tick();
        bus.HRDATA = 32'hCAFE_0014;
        tick();
        bus.HRDATA = 32'd0;
        @(negedge HCLK);
        chk("err_rd_rsp", {31'd0, bus.RSP_VALID}, 32'd1);
        tick();

        // ---- reset while a read is in its data phase ----
        issue(1'b0, 10'h020, 3'd1, 32'h5555_AAAA);
        tick();
        bus.HREADY = 1'b0;
        bus.HRDATA = 32'h0000_0099;
        HRESET     = 1'b1;
        @(negedge HCLK);
        chk("rst2_hwdata_pre", bus.HWDATA, 32'h5555_AAAA);
        tick();
        HRESET     = 1'b0;
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        chk("rst2_htrans", {30'd0, bus.HTRANS}, 32'd0);
        chk("rst2_hsel", {31'd0, bus.HSEL}, 32'd0);
        chk("rst2_haddr", {22'd0, bus.HADDR}, 32'd0);
        chk("rst2_hsize", {29'd0, bus.HSIZE}, 32'd0);
        chk("rst2_hwdata", bus.HWDATA, 32'd0);
        chk("rst2_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("rst2_ready", {31'd0, bus.CMD_READY}, 32'd1);
        chk("rst2_rsp", {31'd0, bus.RSP_VALID}, 32'd0);
        tick();
        @(negedge HCLK);
        chk("rst2_rsp_after", {31'd0, bus.RSP_VALID}, 32'd0);
        bus.HRDATA = 32'd0;
        repeat (2) tick();

`ifdef BFM_AHBMASTER_TIMEOUT_EN
        // ---- timeout after 8 stalled cycles, queued command held ----
        push(32'd0, 1'b1, 1'b1);
        push(32'h3434_3434, 1'b0, 1'b0);
        issue(1'b0, 10'h030, 3'd2, 32'd0);       // cycle N+1
        tick();                                  // N+2
        bus.HREADY = 1'b0;
        tick();                                  // N+3
        set_cmd(1'b0, 10'h034, 3'd2, 32'd0);
        @(negedge HCLK);
        chk("tmo_ready_empty_a", {31'd0, bus.CMD_READY}, 32'd1);
        tick();                                  // N+4
        bus.CMD_VALID = 1'b0;
        @(negedge HCLK);
        chk("tmo_htrans_queued", {30'd0, bus.HTRANS}, 32'h2);
        repeat (5) tick();                       // N+9
        @(negedge HCLK);
        chk("tmo_rsp_early", {31'd0, bus.RSP_VALID}, 32'd0);
        tick();                                  // N+10
        @(negedge HCLK);
        chk("tmo_rsp", {31'd0, bus.RSP_VALID}, 32'd1);
        chk("tmo_htrans_idle", {30'd0, bus.HTRANS}, 32'd0);
        chk("tmo_ready_low", {31'd0, bus.CMD_READY}, 32'd0);
        tick();                                  // N+11
        @(negedge HCLK);
        chk("tmo_htrans_idle2", {30'd0, bus.HTRANS}, 32'd0);
        tick();                                  // N+12
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        chk("tmo_htrans_idle3", {30'd0, bus.HTRANS}, 32'd0);
        tick();                                  // N+13
        @(negedge HCLK);
        chk("tmo_resume_htrans", {30'd0, bus.HTRANS}, 32'h2);
        chk("tmo_resume_haddr", {22'd0, bus.HADDR}, 32'h034);
        tick();                                  // N+14
        bus.HRDATA = 32'h3434_3434;
        tick();                                  // N+15
        bus.HRDATA = 32'd0;
        @(negedge HCLK);
        chk("tmo_rd_rsp", {31'd0, bus.RSP_VALID}, 32'd1);
        tick();
`endif

        repeat (4) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
